// File: rtl/spi_cmd_sequencer_if.sv
// Command/response handshake bundle for spi_cmd_sequencer.
// master: the command producer / response consumer; slave: the sequencer.
interface spi_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SID_W      = 1
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [SID_W-1:0]      cmd_slave_id;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_slave_id, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_slave_id, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues {slave_id, word} commands and launches them one at
// a time on an attached SPI master, collecting the received words.
// Optional macro SPI_SEQ_RX_FIFO_EN: responses go into an RX FIFO of
// FIFO_DEPTH entries instead of a single response register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued command, SPI master idle, response room
// LAUNCH    | one-cycle spi_start with the FIFO head; head is popped
// WAIT_ACK  | waiting for the SPI master to drop spi_ready
// WAIT_DONE | waiting for spi_ready to return; capture spi_rx_data then
module spi_cmd_sequencer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_CS     = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int SID_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_cmd_sequencer_if.slave    bus,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [SID_W-1:0]      spi_slave_id,
  input  logic                  spi_ready,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  busy,
  output logic [LVL_W-1:0]      cmd_level
);

  localparam int ENT_W = SID_W + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [ENT_W-1:0]      cmd_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      cmd_wr, cmd_rd;
  logic [LVL_W-1:0]      cmd_cnt;
  logic [ENT_W-1:0]      head;
  logic [DATA_WIDTH-1:0] last_tx;
  logic [SID_W-1:0]      last_sid;
  logic                  cmd_push, cmd_pop, capture, rsp_pop, rsp_space;

  assign head          = cmd_mem[cmd_rd];
  assign bus.cmd_ready = (cmd_cnt < LVL_W'(FIFO_DEPTH));
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign cmd_pop       = (state == LAUNCH);
  assign capture       = (state == WAIT_DONE) && spi_ready;
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;
  assign cmd_level     = cmd_cnt;
  assign busy          = (cmd_cnt != '0) || (state != IDLE);

  // Command FIFO: power-of-two depth, so pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) cmd_mem[i] <= '0;
      cmd_wr  <= '0;
      cmd_rd  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wr] <= {bus.cmd_slave_id, bus.cmd_data};
        cmd_wr          <= cmd_wr + 1'b1;
      end
      if (cmd_pop) cmd_rd <= cmd_rd + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Remember the launched word so the SPI-side outputs hold between launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tx  <= '0;
      last_sid <= '0;
    end else if (state == LAUNCH) begin
      last_tx  <= head[DATA_WIDTH-1:0];
      last_sid <= head[ENT_W-1:DATA_WIDTH];
    end
  end

  // Next-state and SPI launch outputs.
  always_comb begin
    state_nxt    = state;
    spi_start    = 1'b0;
    spi_tx_data  = last_tx;
    spi_slave_id = last_sid;
    case (state)
      IDLE:      if ((cmd_cnt != '0) && spi_ready && rsp_space) state_nxt = LAUNCH;
      LAUNCH: begin
        spi_start    = 1'b1;
        spi_tx_data  = head[DATA_WIDTH-1:0];
        spi_slave_id = head[ENT_W-1:DATA_WIDTH];
        state_nxt    = WAIT_ACK;
      end
      WAIT_ACK:  if (!spi_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (spi_ready)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef SPI_SEQ_RX_FIFO_EN
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rx_wr, rx_rd;
  logic [LVL_W-1:0]      rx_cnt;
  logic [LVL_W:0]        rx_need;

  // A launch reserves an RX slot for the word it will bring back.
  assign rx_need       = {1'b0, rx_cnt} + {{LVL_W{1'b0}}, (state != IDLE)};
  assign rsp_space     = (rx_need < (LVL_W+1)'(FIFO_DEPTH));
  assign bus.rsp_valid = (rx_cnt != '0);
  assign bus.rsp_data  = rx_mem[rx_rd];

  // RX FIFO: capture pushes, consumer handshake pops; both may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (capture) begin
        rx_mem[rx_wr] <= spi_rx_data;
        rx_wr         <= rx_wr + 1'b1;
      end
      if (rsp_pop) rx_rd <= rx_rd + 1'b1;
      case ({capture, rsp_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end
`else
  logic [DATA_WIDTH-1:0] rsp_reg;
  logic                  rsp_vld;

  // The single register may be refilled only if it is empty or being read now.
  assign rsp_space     = !rsp_vld || rsp_pop;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_reg;

  // Single response register: capture sets valid, pop clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_reg <= '0;
      rsp_vld <= 1'b0;
    end else if (capture) begin
      rsp_reg <= spi_rx_data;
      rsp_vld <= 1'b1;
    end else if (rsp_pop) begin
      rsp_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: queue-based scoreboard with a behavioural
// SPI master model and randomized command/response traffic.
module tb_spi_cmd_sequencer;
  localparam int DW = 8, NCS = 2, DEPTH = 4, SID_W = 1, LVL_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_sequencer_if #(.DATA_WIDTH(DW), .SID_W(SID_W)) bus ();
  logic             spi_start, spi_ready, busy;
  logic [DW-1:0]    spi_tx_data, spi_rx_data;
  logic [SID_W-1:0] spi_slave_id;
  logic [LVL_W-1:0] cmd_level;

  spi_cmd_sequencer #(.DATA_WIDTH(DW), .NUM_CS(NCS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_slave_id(spi_slave_id),
    .spi_ready(spi_ready), .spi_rx_data(spi_rx_data),
    .busy(busy), .cmd_level(cmd_level)
  );

  int checks = 0, errors = 0;
  logic [SID_W+DW-1:0] cmd_exp[$];
  logic [DW-1:0]       rsp_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model
  int            m_phase = 0, m_cnt = 0, lat_fixed = -1, rx_fixed = -1, cap_cyc = 0;
  bit            hold = 0, start_neg = 0, have_cap = 0;
  logic [DW-1:0] m_rx;

  initial begin
    spi_ready   = 1'b1;
    spi_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_phase = 0; spi_ready = 1'b1; have_cap = 0;
      end else begin
        case (m_phase)
          0: if (start_neg) begin
               spi_ready = 1'b0;
               m_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 6));
               m_phase = 1;
             end else spi_ready = !hold;
          1: if (m_cnt == 0) begin
               m_rx = (rx_fixed >= 0) ? DW'(rx_fixed) : DW'($urandom);
               spi_rx_data = m_rx;
               spi_ready = 1'b1;
               rsp_exp.push_back(m_rx);
               m_phase = 2;
             end else m_cnt--;
          default: begin
            cap_cyc = cyc; have_cap = 1; m_phase = 0;
          end
        endcase
      end
    end
  end

  // Response consumer
  int rr_mode = 1;
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard: level, busy, launch order, response order
  int               model_level = 0, n_starts = 0, n_pops = 0;
  bit               push_prev = 0, pop_prev = 0, in_flight = 0, acked = 0, hold_prev = 0;
  logic [DW-1:0]    last_tx = '0, rsp_prev = '0;
  logic [SID_W-1:0] last_sid = '0;
  logic [SID_W+DW-1:0] e;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      model_level = 0; push_prev = 0; pop_prev = 0; in_flight = 0; acked = 0;
      last_tx = '0; last_sid = '0; hold_prev = 0; start_neg = 0;
    end else begin
      model_level += int'(push_prev) - int'(pop_prev);
      chk("cmd_level", cmd_level, model_level);
      chk("cmd_ready", bus.cmd_ready, model_level < DEPTH);
      chk("busy", busy, (model_level != 0) || in_flight || spi_start);
      if (spi_start) begin
        n_starts++;
        chk("start_one_cycle", pop_prev, 0);
        if (have_cap) chk("idle_gap", (cyc - cap_cyc) >= 1, 1);
        if (cmd_exp.size() == 0) fail("unexpected_start");
        else begin
          e = cmd_exp.pop_front();
          chk("tx_data", spi_tx_data, e[DW-1:0]);
          chk("slave_id", spi_slave_id, e[DW+:SID_W]);
        end
        last_tx = spi_tx_data; last_sid = spi_slave_id; in_flight = 1; acked = 0;
      end else begin
        chk("tx_hold", {spi_slave_id, spi_tx_data}, {last_sid, last_tx});
        if (in_flight && !spi_ready) acked = 1;
        else if (in_flight && acked && spi_ready) in_flight = 0;
      end
      if (hold_prev && bus.rsp_valid) chk("rsp_stable", bus.rsp_data, rsp_prev);
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_pops++;
        if (rsp_exp.size() == 0) fail("unexpected_rsp");
        else chk("rsp_data", bus.rsp_data, rsp_exp.pop_front());
      end
      hold_prev = bus.rsp_valid && !bus.rsp_ready;
      rsp_prev  = bus.rsp_data;
      push_prev = bus.cmd_valid && bus.cmd_ready;
      pop_prev  = spi_start;
      start_neg = spi_start;
    end
  end

  int acc_starts = 0;

  task automatic push_cmd(input logic [DW-1:0] d, input logic [SID_W-1:0] s);
    int t = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_data = d; bus.cmd_slave_id = s;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        cmd_exp.push_back({s, d});
        acc_starts = n_starts;
        break;
      end
      t++;
      if (t > 300) begin fail("push_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    rr_mode = 1;
    while (!(busy == 1'b0 && !bus.rsp_valid && rsp_exp.size() == 0 && cmd_exp.size() == 0)) begin
      @(negedge clk);
      t++;
      if (t > budget) begin fail("drain_timeout"); break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_spi_start"}, spi_start, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_cmd_level"}, cmd_level, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_tx_data"}, spi_tx_data, 0);
    chk({tag, "_slave_id"}, spi_slave_id, 0);
  endtask

  int s0, t;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_slave_id = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_start_idle", n_starts, 0);

    // Single word 0xA5 -> 0x3C with a slow master
    s0 = n_starts; rr_mode = 0; lat_fixed = 15; rx_fixed = 8'h3C;
    push_cmd(8'hA5, 1'b0);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin @(negedge clk); t++; end
    chk("a5_rsp_valid", bus.rsp_valid, 1);
    chk("a5_rsp_data", bus.rsp_data, 8'h3C);
    chk("a5_one_start", n_starts - s0, 1);
    lat_fixed = -1; rx_fixed = -1;
    drain(200);

    // Ordered stream 0x01..0x04, consumer always ready
    rr_mode = 1;
    for (int i = 1; i <= 4; i++) push_cmd(DW'(i), SID_W'(i % 2));
    drain(300);

    // Fill the FIFO while the master is held busy
    hold = 1; @(posedge clk); @(posedge clk);
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_cmd(DW'(8'h40 + i), SID_W'(i % 2));
    @(negedge clk);
    chk("full_level", cmd_level, 4);
    chk("full_ready", bus.cmd_ready, 0);
    chk("full_no_start", n_starts - s0, 0);
    hold = 0;
    push_cmd(8'h44, 1'b1);
    chk("fifth_after_launch", (acc_starts - s0) >= 1, 1);
    drain(400);

    // Simultaneous push and pop at level 2
    hold = 1; @(posedge clk); @(posedge clk);
    push_cmd(8'h11, 1'b0);
    push_cmd(8'h22, 1'b1);
    @(negedge clk); hold = 0;
    @(posedge clk);
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h33; bus.cmd_slave_id = 1'b0;
    cmd_exp.push_back({1'b0, 8'h33});
    @(negedge clk);
    chk("pushpop_launch", spi_start, 1);
    chk("pushpop_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_level", cmd_level, 2);
    drain(400);

    // Response back-pressure
    rr_mode = 0; s0 = n_starts;
    push_cmd(8'h5A, 1'b0);
    push_cmd(8'hC3, 1'b1);
    repeat (60) @(negedge clk);
`ifdef SPI_SEQ_RX_FIFO_EN
    chk("bp_starts", n_starts - s0, 2);
`else
    chk("bp_starts", n_starts - s0, 1);
`endif
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    drain(300);
    chk("bp_starts_after", n_starts - s0, 2);

    // Randomized traffic
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_cmd(DW'($urandom), SID_W'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain(2000);

    // Reset in WAIT_DONE with 3 words queued
    rr_mode = 1; lat_fixed = 40;
    for (int i = 0; i < 4; i++) push_cmd(DW'(8'h70 + i), SID_W'(i % 2));
    t = 0;
    while (m_phase != 1 && t < 100) begin @(negedge clk); t++; end
    if (m_phase != 1) fail("reach_wait_done");
    repeat (2) @(negedge clk);
    chk("pre_reset_level", cmd_level, 3);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #3 rst_n = 1'b0;
    cmd_exp.delete(); rsp_exp.delete(); lat_fixed = -1;
    #1 chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    s0 = n_starts;
    repeat (20) @(negedge clk);
    chk("no_start_after_reset", n_starts - s0, 0);
    chk("post_reset_busy", busy, 0);
    push_cmd(8'h96, 1'b1);
    drain(300);
    chk("post_reset_one_start", n_starts - s0, 1);
    chk("cmd_queue_empty", cmd_exp.size(), 0);
    chk("rsp_queue_empty", rsp_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
